// File: rtl/chunked_add_sequencer.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit ripple slice per cycle, LSB slice first,
// valid/ready on both sides. Define ADD_SEQ_OVF_EN to add the signed-overflow output ovf.
module chunked_add_sequencer #(
  parameter int WIDTH   = 64,
  parameter int CHUNK   = 16,
  parameter int USE_AOI = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef ADD_SEQ_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("chunked_add_sequencer: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              cy_q, cy_d, co_q, co_d;
`ifdef ADD_SEQ_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0]  slc_a, slc_b, slc_sum;
  logic [CHUNK:0]    slc_c;

  // Operand slice select by index; only the live slice feeds the carry chain.
  always_comb begin
    slc_a = '0;
    slc_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        slc_a = a_q[i*CHUNK +: CHUNK];
        slc_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // CHUNK-bit ripple-carry slice; USE_AOI picks the and-or-invert carry cell.
  assign slc_c[0] = cy_q;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    logic p;
    assign p          = slc_a[i] ^ slc_b[i];
    assign slc_sum[i] = p ^ slc_c[i];
    if (USE_AOI != 0) begin : g_aoi
      assign slc_c[i+1] = ~(~(slc_a[i] & slc_b[i]) & ~(slc_c[i] & (slc_a[i] | slc_b[i])));
    end else begin : g_std
      assign slc_c[i+1] = (slc_a[i] & slc_b[i]) | (slc_c[i] & p);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    co_d    = co_q;
`ifdef ADD_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          cy_d    = ci;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (idx_q == IDXW'(i)) sum_d[i*CHUNK +: CHUNK] = slc_sum;
        end
        cy_d  = slc_c[CHUNK];
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          co_d    = slc_c[CHUNK];
          idx_d   = '0;
          state_d = DONE;
`ifdef ADD_SEQ_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slc_sum[CHUNK-1] != a_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
`ifdef ADD_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake outputs are pure state decodes: no path from out_ready to in_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign co        = co_q;
`ifdef ADD_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
